// File: rtl/vz_load_ctrl.sv
// VZ image loader: parses the download header, streams image bytes into RAM and
// patches the BASIC end pointer, arbitrating the RAM port against the CPU.
module vz_load_ctrl #(
    parameter logic [7:0] VZ_INDEX = 8'd1
) (
    input  logic        CLK10MHZ,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic [7:0]  dn_index,
    input  logic        cpu_mreq,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_wait_n,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    output logic        load_busy,
    output logic        load_err,
    output logic        load_done,
    output logic [15:0] load_start,
    output logic [15:0] load_end
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StPatch0,
        StPatch1,
        StDone,
        StErr
    } state_e;

    localparam logic [15:0] PatchLoAddr = 16'h78F9;
    localparam logic [15:0] PatchHiAddr = 16'h78FA;
    localparam logic [15:0] HdrLen      = 16'd24;
    localparam logic [7:0]  BasicType   = 8'hF0;

    state_e      state_q;
    logic        dl_q;
    logic [15:0] exp_q;
    logic [7:0]  type_q;
    logic [15:0] start_q;
    logic [15:0] end_q;
    logic        wr_q;
    logic [15:0] waddr_q;
    logic [7:0]  wdata_q;
    logic        done_q;
    logic        err_q;

    logic        busy;
    logic        start_hit;
    logic        off_ok;
    logic        magic_bad;
    logic [7:0]  magic_byte;
    logic [15:0] data_addr;

    assign busy = (state_q == StHdr) || (state_q == StData) ||
                  (state_q == StPatch0) || (state_q == StPatch1);

    assign start_hit = dn_download && !dl_q && (dn_index == VZ_INDEX);
    assign off_ok    = (dn_addr == exp_q);
    assign data_addr = start_q + (dn_addr - HdrLen);

    always_comb begin
        magic_byte = 8'h00;
        case (exp_q[1:0])
            2'd0: magic_byte = 8'h56;
            2'd1: magic_byte = 8'h5A;
            2'd2: magic_byte = 8'h46;
            2'd3: magic_byte = 8'h30;
            default: magic_byte = 8'h00;
        endcase
    end

    assign magic_bad = (exp_q < 16'd4) && (dn_data != magic_byte);

    always_ff @(posedge CLK10MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            // Treat a download already in progress at reset as stale: only a fresh rise starts.
            dl_q    <= 1'b1;
            exp_q   <= '0;
            type_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dl_q   <= dn_download;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_hit) begin
                        state_q <= StHdr;
                        exp_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                StHdr: begin
                    if (!dn_download) begin
                        state_q <= StErr;
                        err_q   <= 1'b1;
                    end else if (dn_wr) begin
                        if (!off_ok || magic_bad) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else begin
                            exp_q <= exp_q + 16'd1;
                            if (exp_q == 16'd21) type_q <= dn_data;
                            if (exp_q == 16'd22) start_q[7:0] <= dn_data;
                            if (exp_q == 16'd23) begin
                                start_q[15:8] <= dn_data;
                                end_q         <= {dn_data, start_q[7:0]};
                                state_q       <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    // A byte arriving with the download fall is written first; the fall
                    // is acted on next cycle while the write is still on the port.
                    if (dn_wr) begin
                        if (!off_ok) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else begin
                            wr_q    <= 1'b1;
                            waddr_q <= data_addr;
                            wdata_q <= dn_data;
                            end_q   <= data_addr + 16'd1;
                            exp_q   <= exp_q + 16'd1;
                        end
                    end else if (!dn_download) begin
                        if (type_q == BasicType) begin
                            state_q <= StPatch0;
                            wr_q    <= 1'b1;
                            waddr_q <= PatchLoAddr;
                            wdata_q <= end_q[7:0];
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StPatch0: begin
                    state_q <= StPatch1;
                    wr_q    <= 1'b1;
                    waddr_q <= PatchHiAddr;
                    wdata_q <= end_q[15:8];
                end
                StPatch1: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone, StErr: begin
                    if (start_hit) begin
                        state_q <= StHdr;
                        exp_q   <= '0;
                        err_q   <= 1'b0;
                    end else if (!dn_download) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign load_busy  = busy;
    assign cpu_wait_n = busy ? ~cpu_mreq : 1'b1;
    assign ram_addr   = busy ? waddr_q : cpu_addr;
    assign ram_din    = busy ? wdata_q : cpu_dout;
    assign ram_we     = busy ? wr_q : (cpu_mreq & cpu_wr);
    assign load_err   = err_q;
    assign load_done  = done_q;
    assign load_start = start_q;
    assign load_end   = end_q;

endmodule

// File: tb/tb_vz_load_ctrl.sv
// Self-checking bench for vz_load_ctrl: directed and randomized image loads compared
// against a write-list model of the image layout, with per-cycle port arbitration checks.
module tb_vz_load_ctrl;

    localparam logic [7:0] VZ = 8'd1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dn_download, dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data, dn_index;
    logic        cpu_mreq, cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wait_n, ram_we, load_busy, load_err, load_done;
    logic [15:0] ram_addr, load_start, load_end;
    logic [7:0]  ram_din;

    always #50 clk = ~clk;

    vz_load_ctrl #(.VZ_INDEX(VZ)) dut (
        .CLK10MHZ   (clk),
        .RESET      (rst_n),
        .dn_download(dn_download),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .dn_index   (dn_index),
        .cpu_mreq   (cpu_mreq),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .load_busy  (load_busy),
        .load_err   (load_err),
        .load_done  (load_done),
        .load_start (load_start),
        .load_end   (load_end)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          cpu_mode = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [7:0]  img[$];
    logic [15:0] mon_a;
    logic [7:0]  mon_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Port arbitration rules and RAM write scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (load_done === 1'b1) done_cnt++;
            if (load_busy !== 1'b1) begin
                chk("pass_addr", {16'h0, ram_addr}, {16'h0, cpu_addr});
                chk("pass_din", {24'h0, ram_din}, {24'h0, cpu_dout});
                chk("pass_we", {31'h0, ram_we}, {31'h0, cpu_mreq & cpu_wr});
                chk("pass_wait", {31'h0, cpu_wait_n}, 32'd1);
            end else begin
                chk("busy_wait", {31'h0, cpu_wait_n}, {31'h0, ~cpu_mreq});
                if (ram_we === 1'b1) begin
                    if (exp_addr.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %h data %h, want no write",
                                 ram_addr, ram_din);
                    end else begin
                        mon_a = exp_addr.pop_front();
                        mon_d = exp_data.pop_front();
                        chk("wr_addr", {16'h0, ram_addr}, {16'h0, mon_a});
                        chk("wr_data", {24'h0, ram_din}, {24'h0, mon_d});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            tick();
            case (cpu_mode)
                1: begin
                    cpu_mreq = 1'($urandom);
                    cpu_wr   = 1'($urandom);
                    cpu_addr = 16'($urandom);
                    cpu_dout = 8'($urandom);
                end
                2: begin
                    cpu_mreq = 1'b1;
                    cpu_wr   = 1'b1;
                    cpu_addr = 16'($urandom);
                    cpu_dout = 8'($urandom);
                end
                default: begin
                    cpu_mreq = 1'b0;
                    cpu_wr   = 1'b0;
                end
            endcase
        end
    end

    task automatic push_w(input logic [15:0] a, input logic [7:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    // Image model: bytes land at start+i, BASIC images then store end = start+n at 0x78F9.
    task automatic push_model(input logic [15:0] start, input bit patch);
        logic [15:0] e;
        for (int i = 0; i < img.size(); i++) push_w(start + 16'(i), img[i]);
        e = start + 16'(img.size());
        if (patch) begin
            push_w(16'h78F9, e[7:0]);
            push_w(16'h78FA, e[15:8]);
        end
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit fall);
        tick();
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        if (fall) dn_download = 1'b0;
        tick();
        dn_wr = 1'b0;
        repeat ($urandom_range(2)) tick();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        tick();
        dn_index    = idx;
        dn_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        tick();
        dn_download = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] typ, input logic [15:0] start, input int upto,
                               input bit bad);
        logic [7:0] b;
        for (int i = 0; i < upto; i++) begin
            case (i)
                0: b = 8'h56;
                1: b = 8'h5A;
                2: b = bad ? 8'h47 : 8'h46;
                3: b = 8'h30;
                21: b = typ;
                22: b = start[7:0];
                23: b = start[15:8];
                default: b = 8'($urandom);
            endcase
            send_byte(16'(i), b, 1'b0);
        end
    endtask

    task automatic send_data(input bit together);
        for (int i = 0; i < img.size(); i++)
            send_byte(16'(24 + i), img[i], together && (i == img.size() - 1));
    endtask

    task automatic finish_load(input logic [15:0] start);
        for (int i = 0; i < 60 && done_cnt == 0; i++) @(negedge clk);
        chk("done_seen", {31'h0, (done_cnt > 0)}, 32'd1);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 32'd1);
        chk("busy_after", {31'h0, load_busy}, 32'd0);
        chk("err_after", {31'h0, load_err}, 32'd0);
        chk("load_start", {16'h0, load_start}, {16'h0, start});
        chk("load_end", {16'h0, load_end}, {16'h0, start + 16'(img.size())});
        chk("writes_left", exp_addr.size(), 32'd0);
    endtask

    task automatic run_load(input logic [7:0] typ, input logic [15:0] start, input bit together,
                            input bit model);
        if (model) push_model(start, typ == 8'hF0);
        done_cnt = 0;
        start_dl(VZ);
        send_header(typ, start, 24, 1'b0);
        @(negedge clk);
        chk("hdr_busy", {31'h0, load_busy}, 32'd1);
        if (cpu_mode == 2) chk("cpu_wait_data", {31'h0, cpu_wait_n}, 32'd0);
        send_data(together);
        if (!together) end_dl();
        finish_load(start);
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", {31'h0, load_busy}, 32'd0);
        chk("rst_err", {31'h0, load_err}, 32'd0);
        chk("rst_done", {31'h0, load_done}, 32'd0);
        chk("rst_start", {16'h0, load_start}, 32'd0);
        chk("rst_end", {16'h0, load_end}, 32'd0);
        chk("rst_wait", {31'h0, cpu_wait_n}, 32'd1);
        chk("rst_we", {31'h0, ram_we}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  typ;
        logic [15:0] start;
        rst_n = 1'b0;
        dn_download = 1'b0;
        dn_wr = 1'b0;
        dn_addr = '0;
        dn_data = '0;
        dn_index = '0;
        cpu_mreq = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        cpu_dout = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        mon_en = 1'b1;
        #1 rst_n = 1'b1;
        repeat (2) tick();

        // BASIC image with literal expectations.
        img = {8'h11, 8'h22, 8'h33};
        push_w(16'h7AE9, 8'h11);
        push_w(16'h7AEA, 8'h22);
        push_w(16'h7AEB, 8'h33);
        push_w(16'h78F9, 8'hEC);
        push_w(16'h78FA, 8'h7A);
        run_load(8'hF0, 16'h7AE9, 1'b0, 1'b0);
        chk("basic_end_lit", {16'h0, load_end}, 32'h7AEC);

        // Binary image while the CPU hammers writes.
        cpu_mode = 2;
        img = {8'hA5, 8'h5A};
        push_w(16'h8000, 8'hA5);
        push_w(16'h8001, 8'h5A);
        run_load(8'hF1, 16'h8000, 1'b0, 1'b0);
        chk("bin_end_lit", {16'h0, load_end}, 32'h8002);
        chk("wait_after_done", {31'h0, cpu_wait_n}, 32'd1);
        cpu_mode = 0;
        repeat (2) tick();

        // Address wrap, last byte coincident with the download fall.
        img = {8'hC3, 8'h3C};
        push_w(16'hFFFF, 8'hC3);
        push_w(16'h0000, 8'h3C);
        run_load(8'hF1, 16'hFFFF, 1'b1, 1'b0);
        chk("wrap_end_lit", {16'h0, load_end}, 32'h0001);
        repeat (2) tick();

        // Bad magic byte.
        done_cnt = 0;
        start_dl(VZ);
        send_header(8'hF0, 16'h1234, 3, 1'b1);
        @(negedge clk);
        chk("magic_err", {31'h0, load_err}, 32'd1);
        chk("magic_busy", {31'h0, load_busy}, 32'd0);
        cpu_mode = 1;
        for (int i = 3; i < 30; i++) send_byte(16'(i), 8'($urandom), 1'b0);
        end_dl();
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'h0, load_err}, 32'd1);
        chk("magic_no_done", done_cnt, 32'd0);
        cpu_mode = 0;
        repeat (2) tick();

        // Truncated header, then a new download rises straight out of the error.
        rand_img(4);
        start = 16'($urandom);
        push_model(start, 1'b0);
        done_cnt = 0;
        start_dl(VZ);
        send_header(8'h20, start, 10, 1'b0);
        tick();
        dn_download = 1'b0;
        tick();
        dn_download = 1'b1;
        @(negedge clk);
        chk("trunc_err", {31'h0, load_err}, 32'd1);
        send_header(8'h20, start, 24, 1'b0);
        send_data(1'b0);
        end_dl();
        finish_load(start);
        repeat (2) tick();

        // Out-of-sequence data offset.
        rand_img(2);
        start = 16'h4000;
        push_model(start, 1'b0);
        done_cnt = 0;
        start_dl(VZ);
        send_header(8'hF0, start, 24, 1'b0);
        send_data(1'b0);
        send_byte(16'd27, 8'h99, 1'b0);
        @(negedge clk);
        chk("skip_err", {31'h0, load_err}, 32'd1);
        end_dl();
        repeat (3) @(negedge clk);
        chk("skip_writes_left", exp_addr.size(), 32'd0);
        chk("skip_no_done", done_cnt, 32'd0);
        repeat (2) tick();

        // Download for another menu index is ignored.
        done_cnt = 0;
        start_dl(VZ + 8'd1);
        send_header(8'hF0, 16'h5000, 24, 1'b0);
        @(negedge clk);
        chk("foreign_busy", {31'h0, load_busy}, 32'd0);
        end_dl();
        repeat (3) @(negedge clk);
        chk("foreign_no_done", done_cnt, 32'd0);

        for (int it = 0; it < 16; it++) begin
            cpu_mode = int'($urandom_range(2));
            typ = 8'($urandom);
            if ($urandom_range(1) == 1) typ = 8'hF0;
            else if (typ == 8'hF0) typ = 8'hF1;
            start = ($urandom_range(3) == 0) ? (16'hFFF8 + 16'($urandom_range(7)))
                                             : 16'($urandom);
            rand_img(int'($urandom_range(12, 1)));
            run_load(typ, start, 1'($urandom), 1'b1);
            repeat (2) tick();
        end
        cpu_mode = 0;
        repeat (2) tick();

        // Reset after 10 data bytes of a BASIC image: no patch, later bytes ignored.
        rand_img(10);
        start = 16'h6000;
        push_model(start, 1'b0);
        done_cnt = 0;
        start_dl(VZ);
        send_header(8'hF0, start, 24, 1'b0);
        send_data(1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 34; i < 40; i++) send_byte(16'(i), 8'($urandom), 1'b0);
        @(negedge clk);
        chk("post_rst_busy", {31'h0, load_busy}, 32'd0);
        end_dl();
        repeat (4) @(negedge clk);
        chk("rst_writes_left", exp_addr.size(), 32'd0);
        chk("rst_no_done", done_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
